uart_rx_frame_bridge: RTL and testbench

Parametrised successor to the fixed-size UART receive bridge. It sits between the byte-level UART receiver and the controller. It parses framed packets of the form START_BYTE, header, length, payload and XOR checksum. The payload length is variable, bytes are validated, and completed frames are held in a two-slot ping-pong buffer, so a new frame can be received while the controller holds the previous one.

---
 rtl/uart_rx_frame_bridge.sv | 111 +++++++++++
 tb/tb_uart_rx_frame_bridge.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_bridge.sv
// uart_rx_frame_bridge: parses START/header/length/payload/XOR frames into a two-slot ping-pong buffer
module uart_rx_frame_bridge #(
  parameter int HEADER_BYTES = 4,
  parameter int MAX_PAYLOAD_BYTES = 64,
  parameter logic [7:0] START_BYTE = 8'hBB,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic [7:0] ll_byte_in,
  input  logic ll_valid_in,
  output logic ll_ready_out,
  output logic [HEADER_BYTES*8-1:0] header_out,
  output logic [MAX_PAYLOAD_BYTES*8-1:0] message_out,
  output logic [$clog2(MAX_PAYLOAD_BYTES+1)-1:0] length_out,
  output logic bdge_valid_out,
  input  logic ctrl_ready_in,
  output logic err_checksum_out,
  output logic err_length_out,
  output logic err_timeout_out,
  output logic [15:0] drop_count_out
);
  localparam int LW = $clog2(MAX_PAYLOAD_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = $clog2((HEADER_BYTES > MAX_PAYLOAD_BYTES ? HEADER_BYTES : MAX_PAYLOAD_BYTES) + 1);
  typedef enum logic [2:0] {IDLE, HEADER, LENGTH, PAYLOAD, CHECK} state_t;
  state_t state, state_n;
  logic [7:0] csum, len;
  logic [IW-1:0] idx;
  logic [TW-1:0] tcnt;
  logic [HEADER_BYTES*8-1:0] hdr_w, hdr_s [2];
  logic [MAX_PAYLOAD_BYTES*8-1:0] msg_w, msg_s [2];
  logic [7:0] len_s [2];
  logic wr, rd;
  logic [1:0] cnt;
  logic acc, take, timeout, bad_len, hdr_last, pay_last, commit, mismatch, len_err;
  assign ll_ready_out = !(state == IDLE && cnt == 2'd2);
  assign acc = ll_valid_in && ll_ready_out;
  assign bdge_valid_out = cnt != 2'd0;
  assign take = bdge_valid_out && ctrl_ready_in;
  assign header_out = hdr_s[rd];
  assign message_out = msg_s[rd];
  assign length_out = LW'(len_s[rd]);
  assign timeout = state != IDLE && !acc && 32'(tcnt) == TIMEOUT_CYCLES - 1;
  assign bad_len = ll_byte_in == 8'd0 || 32'(ll_byte_in) > MAX_PAYLOAD_BYTES;
  assign hdr_last = 32'(idx) == HEADER_BYTES - 1;
  assign pay_last = 32'(idx) == 32'(len) - 1;
  assign commit = acc && state == CHECK && ll_byte_in == csum;
  assign mismatch = acc && state == CHECK && ll_byte_in != csum;
  assign len_err = acc && state == LENGTH && bad_len;
  // state register
  always_ff @(posedge clk_in) state <= rst_in ? IDLE : state_n;
  // next state: advance on accepted bytes, abort to IDLE on timeout
  always_comb begin
    state_n = state;
    if (timeout) state_n = IDLE;
    else if (acc)
      case (state)
        IDLE:    state_n = ll_byte_in == START_BYTE ? HEADER : IDLE;
        HEADER:  state_n = hdr_last ? LENGTH : HEADER;
        LENGTH:  state_n = bad_len ? IDLE : PAYLOAD;
        PAYLOAD: state_n = pay_last ? CHECK : PAYLOAD;
        default: state_n = IDLE;
      endcase
  end
  // frame assembly; payload buffer is cleared at frame start so bytes above L commit as zero
  always_ff @(posedge clk_in) begin
    if (acc) begin
      csum <= state == IDLE ? 8'd0 : csum ^ ll_byte_in;
      idx <= (state == IDLE || state == LENGTH || (state == HEADER && hdr_last)) ? '0 : idx + 1'b1;
      len <= state == LENGTH ? ll_byte_in : len;
      if (state == IDLE) msg_w <= '0;
      for (int k = 0; k < HEADER_BYTES; k++)
        if (state == HEADER && 32'(idx) == k) hdr_w[8*k +: 8] <= ll_byte_in;
      for (int k = 0; k < MAX_PAYLOAD_BYTES; k++)
        if (state == PAYLOAD && 32'(idx) == k) msg_w[8*k +: 8] <= ll_byte_in;
    end
  end
  // slot buffer, inter-byte timer and error reporting
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int k = 0; k < 2; k++) begin
        hdr_s[k] <= '0;
        msg_s[k] <= '0;
        len_s[k] <= '0;
      end
      wr <= 1'b0;
      rd <= 1'b0;
      cnt <= 2'd0;
      tcnt <= '0;
      err_checksum_out <= 1'b0;
      err_length_out <= 1'b0;
      err_timeout_out <= 1'b0;
      drop_count_out <= 16'd0;
    end else begin
      if (commit) begin
        hdr_s[wr] <= hdr_w;
        msg_s[wr] <= msg_w;
        len_s[wr] <= len;
        wr <= ~wr;
      end
      if (take) rd <= ~rd;
      cnt <= cnt + {1'b0, commit} - {1'b0, take};
      tcnt <= (acc || state == IDLE || timeout) ? '0 : tcnt + 1'b1;
      err_checksum_out <= mismatch;
      err_length_out <= len_err;
      err_timeout_out <= timeout;
      drop_count_out <= ((mismatch || len_err || timeout) && drop_count_out != 16'hFFFF) ? drop_count_out + 16'd1 : drop_count_out;
    end
  end
endmodule

// File: tb/tb_uart_rx_frame_bridge.sv
// tb_uart_rx_frame_bridge: directed frame scenarios with hand-computed expectations
module tb_uart_rx_frame_bridge;
  logic clk = 0, rst, ll_valid, ll_ready, valid, ctrl_ready;
  logic [7:0] ll_byte;
  logic [31:0] header;
  logic [511:0] message;
  logic [6:0] length;
  logic err_cs, err_len, err_to;
  logic [15:0] drop;
  int n_chk = 0, n_err = 0, n_cs = 0, n_len = 0, n_to = 0, base;
  logic [31:0] cap_h [$];
  logic [6:0] cap_l [$];
  logic [511:0] cap_m [$];
  localparam logic [87:0] F1 = 88'hBBFAFAFAFA040123456704;
  localparam logic [63:0] FA = 64'hBB1122334401AAEF;
  localparam logic [71:0] FB = 72'hBB0102030402556635;
  uart_rx_frame_bridge #(.TIMEOUT_CYCLES(50)) dut (
    .clk_in(clk), .rst_in(rst), .ll_byte_in(ll_byte), .ll_valid_in(ll_valid), .ll_ready_out(ll_ready),
    .header_out(header), .message_out(message), .length_out(length), .bdge_valid_out(valid),
    .ctrl_ready_in(ctrl_ready), .err_checksum_out(err_cs), .err_length_out(err_len),
    .err_timeout_out(err_to), .drop_count_out(drop)
  );
  always #5 clk = ~clk;
  // counts error-pulse cycles and records every frame the controller accepts
  always @(posedge clk) begin
    if (rst) begin
      n_cs <= 0;
      n_len <= 0;
      n_to <= 0;
    end else begin
      if (err_cs) n_cs <= n_cs + 1;
      if (err_len) n_len <= n_len + 1;
      if (err_to) n_to <= n_to + 1;
      if (valid && ctrl_ready) begin
        cap_h.push_back(header);
        cap_l.push_back(length);
        cap_m.push_back(message);
      end
    end
  end
  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send_bytes(input logic [127:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      ll_byte = v[8*(n-1-i) +: 8];
      ll_valid = 1;
      tick(1);
    end
    ll_valid = 0;
  endtask
  task automatic expect_frame(input string tag, input int i, input logic [31:0] h, input logic [6:0] l, input logic [511:0] m);
    if (cap_h.size() > i) begin
      chk({tag, "_hdr"}, cap_h[i], h);
      chk({tag, "_len"}, cap_l[i], l);
      chk({tag, "_msg"}, cap_m[i], m);
    end else chk({tag, "_count"}, cap_h.size(), i + 1);
  endtask
  initial begin
    rst = 1; ll_valid = 0; ll_byte = 0; ctrl_ready = 0;
    tick(3);
    chk("rst_valid", valid, 0);
    chk("rst_ready", ll_ready, 1);
    chk("rst_hdr", header, 0);
    chk("rst_len", length, 0);
    chk("rst_msg", message, 0);
    chk("rst_drop", drop, 0);
    rst = 0;
    tick(1);
    ctrl_ready = 1;
    base = cap_h.size();
    send_bytes(F1, 11);
    chk("s1_valid", valid, 1);
    chk("s1_hdr", header, 32'hFAFAFAFA);
    chk("s1_len", length, 4);
    chk("s1_msg", message, 512'h67452301);
    tick(1);
    chk("s1_valid_drop", valid, 0);
    expect_frame("s1", base, 32'hFAFAFAFA, 4, 512'h67452301);
    chk("s1_errs", n_cs + n_len + n_to, 0);
    ctrl_ready = 0;
    base = cap_h.size();
    send_bytes(FA, 8);
    send_bytes(FB, 9);
    chk("s2_ready_full", ll_ready, 0);
    chk("s2_hdr_a", header, 32'h44332211);
    ll_byte = 8'hBB;
    ll_valid = 1;
    tick(3);
    chk("s2_ready_hold", ll_ready, 0);
    chk("s2_valid_hold", valid, 1);
    ctrl_ready = 1;
    tick(1);
    ctrl_ready = 0;
    chk("s2_hdr_b", header, 32'h04030201);
    chk("s2_len_b", length, 2);
    chk("s2_msg_b", message, 512'h6655);
    chk("s2_ready_back", ll_ready, 1);
    chk("s2_valid_kept", valid, 1);
    tick(1);
    ll_valid = 0;
    send_bytes(80'hFAFAFAFA040123456704, 10);
    ctrl_ready = 1;
    tick(3);
    expect_frame("s2a", base, 32'h44332211, 1, 512'hAA);
    expect_frame("s2b", base + 1, 32'h04030201, 2, 512'h6655);
    expect_frame("s2c", base + 2, 32'hFAFAFAFA, 4, 512'h67452301);
    chk("s2_empty", valid, 0);
    base = cap_h.size();
    send_bytes(88'hBBFAFAFAFA040123456705, 11);
    tick(2);
    chk("s3_err_cs", n_cs, 1);
    chk("s3_drop", drop, 1);
    chk("s3_valid", valid, 0);
    chk("s3_none", cap_h.size(), base);
    send_bytes(F1, 11);
    tick(2);
    expect_frame("s3", base, 32'hFAFAFAFA, 4, 512'h67452301);
    chk("s3_cs_once", n_cs, 1);
    send_bytes(64'hBBFAFAFAFA040123, 8);
    tick(49);
    chk("s4_early", err_to, 0);
    tick(1);
    chk("s4_pulse", err_to, 1);
    chk("s4_drop", drop, 2);
    tick(10);
    chk("s4_once", n_to, 1);
    base = cap_h.size();
    send_bytes(F1, 11);
    tick(2);
    expect_frame("s4", base, 32'hFAFAFAFA, 4, 512'h67452301);
    rst = 1;
    tick(1);
    rst = 0;
    base = cap_h.size();
    send_bytes(48'hBBFAFAFAFA00, 6);
    send_bytes(40'h0123456704, 5);
    send_bytes(48'hBBFAFAFAFA41, 6);
    send_bytes(40'h0123456704, 5);
    tick(2);
    chk("s5_err_len", n_len, 2);
    chk("s5_drop", drop, 2);
    chk("s5_none", cap_h.size(), base);
    send_bytes(F1, 11);
    tick(2);
    expect_frame("s5", base, 32'hFAFAFAFA, 4, 512'h67452301);
    ctrl_ready = 0;
    send_bytes(F1, 11);
    chk("s6_buffered", valid, 1);
    send_bytes(64'hBBFAFAFAFA040123, 8);
    rst = 1;
    tick(1);
    rst = 0;
    chk("s6_valid", valid, 0);
    chk("s6_ready", ll_ready, 1);
    chk("s6_drop", drop, 0);
    base = cap_h.size();
    ctrl_ready = 1;
    send_bytes(FB, 9);
    tick(2);
    expect_frame("s6", base, 32'h04030201, 2, 512'h6655);
    chk("s6_count", cap_h.size(), base + 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_chk, n_err);
    $finish;
  end
endmodule
